// File: rtl/weight_loader.sv
// Streams neuron weights from a word-wide ROM into per-neuron FIFOs, one word per
// FETCH/CAPTURE/WRITE round, stalling on the target FIFO's full flag only.
module weight_loader #(
    parameter int  NO_IPN   = 4,
    parameter int  NO_NPL   = 4,
    parameter int  WEIGHT_W = 4,
    parameter int  WORD_W   = 16,
    localparam int WPN      = NO_IPN * WEIGHT_W / WORD_W,
    localparam int N_WORDS  = NO_NPL * WPN,
    localparam int ADDR_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rom_r_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic [NO_NPL-1:0] node_wr_en,
    output logic [WORD_W-1:0] node_data,
    input  logic [NO_NPL-1:0] node_full,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [NO_NPL-1:0] tgt_oh;
    logic              tgt_full;

    // Target neuron is addr / WPN; a range compare per neuron avoids a divider.
    always_comb begin
        tgt_oh = '0;
        for (int n = 0; n < NO_NPL; n++) begin
            if (int'(addr_q) >= n * WPN && int'(addr_q) < (n + 1) * WPN)
                tgt_oh[n] = 1'b1;
        end
    end

    assign tgt_full = |(tgt_oh & node_full);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        rom_r_en   = 1'b0;
        node_wr_en = '0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                rom_r_en = 1'b1;
                state_d  = S_CAPTURE;
            end
            S_CAPTURE: begin
                word_d  = rom_data;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                // A full target holds word and address; no timeout by design.
                if (!tgt_full) begin
                    node_wr_en = tgt_oh;
                    cnt_d      = cnt_q + (ADDR_W + 1)'(1);
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rom_addr      = addr_q;
    assign node_data     = word_q;
    assign busy          = (state_q != S_IDLE);
    assign words_written = cnt_q;

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: per-cycle comparison against an event-time model derived
// from the load rules (fetch, +2 to write, stall while target full, done after last).
module tb_weight_loader;

    localparam int NW   = 4;
    localparam int MAXC = 128;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        rom_r_en;
    logic [1:0]  rom_addr;
    logic [15:0] rom_data;
    logic [3:0]  node_wr_en;
    logic [15:0] node_data;
    logic [3:0]  node_full;
    logic        busy, done;
    logic [2:0]  words_written;

    logic        start8, rom_r_en8, busy8, done8;
    logic [2:0]  rom_addr8;
    logic [15:0] rom_data8, node_data8;
    logic [3:0]  node_wr_en8, node_full8, ww8;

    logic [15:0] rom_mem [NW];
    logic [15:0] rom8_mem [8];
    logic [3:0]  full_sched [MAXC];

    int          errors = 0;
    int          checks = 0;
    logic [2:0]  last_ww;
    logic [1:0]  last_addr;
    logic [15:0] last_data;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_r_en)  rom_data  <= rom_mem[rom_addr];
        if (rom_r_en8) rom_data8 <= rom8_mem[rom_addr8];
    end

    weight_loader dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_r_en(rom_r_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .node_wr_en(node_wr_en), .node_data(node_data), .node_full(node_full),
        .busy(busy), .done(done), .words_written(words_written)
    );

    weight_loader #(.NO_IPN(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .rom_r_en(rom_r_en8), .rom_addr(rom_addr8), .rom_data(rom_data8),
        .node_wr_en(node_wr_en8), .node_data(node_data8), .node_full(node_full8),
        .busy(busy8), .done(done8), .words_written(ww8)
    );

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    task automatic clear_sched();
        for (int c = 0; c < MAXC; c++) full_sched[c] = 4'b0000;
    endtask

    // Cycle 0 is the start cycle. With default parameters WPN=1, so word i targets node i.
    task automatic run_load(input int rst_at, input int xs1, input int xs2, input int len);
        int fetch_t[NW];
        int wr_t[NW];
        int t, w, done_t, stop, nwr;
        logic [3:0]  e_wr;
        logic [15:0] e_dat;
        logic        e_dv, e_rd;
        t = 1;
        for (int i = 0; i < NW; i++) begin
            fetch_t[i] = t;
            w = t + 2;
            while (w < MAXC - 1 && full_sched[w][i]) w++;
            wr_t[i] = w;
            t = w + 1;
        end
        done_t = t;
        stop = (len < 0) ? done_t : len;
        for (int c = 0; c <= stop; c++) begin
            start     = (c == 0) || (c == xs1) || (c == xs2);
            rst       = (c == rst_at);
            node_full = full_sched[c];
            @(negedge clk);
            if (rst_at >= 0 && c > rst_at) begin
                chk("busy_after_rst", c, 32'(busy), 0);
                chk("done_after_rst", c, 32'(done), 0);
                chk("rden_after_rst", c, 32'(rom_r_en), 0);
                chk("wren_after_rst", c, 32'(node_wr_en), 0);
                chk("ww_after_rst", c, 32'(words_written), 0);
                chk("addr_after_rst", c, 32'(rom_addr), 0);
                chk("data_after_rst", c, 32'(node_data), 0);
            end else begin
                nwr = 0; e_wr = '0; e_dv = 1'b0; e_dat = '0; e_rd = 1'b0;
                for (int i = 0; i < NW; i++) begin
                    if (wr_t[i] < c) nwr++;
                    if (wr_t[i] == c) e_wr = 4'b0001 << i;
                    if (fetch_t[i] == c) e_rd = 1'b1;
                    if (c >= fetch_t[i] + 2 && c <= wr_t[i]) begin
                        e_dv  = 1'b1;
                        e_dat = rom_mem[i];
                    end
                end
                chk("busy", c, 32'(busy), 32'(c >= 1 && c <= done_t));
                chk("done", c, 32'(done), 32'(c == done_t));
                chk("rom_r_en", c, 32'(rom_r_en), 32'(e_rd));
                chk("node_wr_en", c, 32'(node_wr_en), 32'(e_wr));
                if (c >= 1) begin
                    chk("words_written", c, 32'(words_written), 32'(nwr));
                    chk("rom_addr", c, 32'(rom_addr), 32'((nwr > NW - 1) ? NW - 1 : nwr));
                end
                if (e_dv) chk("node_data", c, 32'(node_data), 32'(e_dat));
            end
            @(posedge clk); #1;
        end
        start = 1'b0; rst = 1'b0; node_full = '0;
        if (rst_at >= 0) begin
            last_ww = '0; last_addr = '0; last_data = '0;
        end else begin
            last_ww = 3'(NW); last_addr = 2'(NW - 1); last_data = rom_mem[NW - 1];
        end
    endtask

    // Idle cycles: nothing moves, results of the last load (or reset) hold.
    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            start = 1'b0; rst = 1'b0; node_full = 4'($urandom);
            @(negedge clk);
            chk("idle_busy", c, 32'(busy), 0);
            chk("idle_done", c, 32'(done), 0);
            chk("idle_rden", c, 32'(rom_r_en), 0);
            chk("idle_wren", c, 32'(node_wr_en), 0);
            chk("idle_ww", c, 32'(words_written), 32'(last_ww));
            chk("idle_addr", c, 32'(rom_addr), 32'(last_addr));
            chk("idle_data", c, 32'(node_data), 32'(last_data));
            @(posedge clk); #1;
        end
        node_full = '0;
    endtask

    initial begin
        int k;
        logic [3:0] e8;
        rst = 1'b1; start = 1'b0; node_full = '0; start8 = 1'b0; node_full8 = '0;
        clear_sched();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        last_ww = '0; last_addr = '0; last_data = '0;
        idle(2);

        // Directed reference load
        rom_mem[0] = 16'h1234; rom_mem[1] = 16'h5678; rom_mem[2] = 16'h9ABC; rom_mem[3] = 16'hDEF0;
        run_load(-1, -1, -1, -1);
        idle(3);

        // Node 2 full for five cycles; node 1 full while node 0 is written (ignored)
        for (int c = 9; c <= 13; c++) full_sched[c][2] = 1'b1;
        full_sched[3][1] = 1'b1;
        run_load(-1, -1, -1, -1);
        clear_sched();
        idle(2);

        // Spurious starts mid-load
        run_load(-1, 5, 10, -1);
        idle(1);

        // Abort at T+7, restart at T+20, then a back-to-back load
        run_load(7, -1, -1, 19);
        run_load(-1, -1, -1, -1);
        run_load(-1, -1, -1, -1);
        idle(2);

        // Reset wins over a simultaneous start
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        last_ww = '0; last_addr = '0; last_data = '0;
        idle(3);

        // Randomised ROM contents, FIFO-full patterns and extra starts
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NW; i++) rom_mem[i] = 16'($urandom);
            clear_sched();
            for (int c = 0; c < 40; c++)
                for (int b = 0; b < 4; b++) full_sched[c][b] = ($urandom_range(0, 3) == 0);
            if (r == 5) begin
                run_load(int'($urandom_range(2, 12)), -1, -1, 15);
                idle(1);
            end else begin
                run_load(-1, int'($urandom_range(2, 10)), -1, -1);
                idle(int'($urandom_range(0, 2)));
            end
        end
        clear_sched();

        // Two words per neuron
        for (int i = 0; i < 8; i++) rom8_mem[i] = 16'($urandom);
        for (int c = 0; c <= 27; c++) begin
            start8 = (c == 0);
            @(negedge clk);
            e8 = '0;
            k = (c - 3) / 3;
            if (c >= 3 && (c - 3) % 3 == 0 && k < 8) begin
                e8 = 4'b0001 << (k / 2);
                chk("w8_data", c, 32'(node_data8), 32'(rom8_mem[k]));
            end
            chk("w8_wren", c, 32'(node_wr_en8), 32'(e8));
            chk("w8_done", c, 32'(done8), 32'(c == 25));
            chk("w8_busy", c, 32'(busy8), 32'(c >= 1 && c <= 25));
            @(posedge clk); #1;
        end
        chk("w8_ww", 28, 32'(ww8), 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameter NO_IPN, default 4: inputs per neuron.
REQ-002 Parameter NO_NPL, default 4: neurons per layer, one weight FIFO per neuron.
REQ-003 Parameter WEIGHT_W, default 4: bits per weight.
REQ-004 Parameter WORD_W, default 16: ROM word width.
REQ-005 Derived WPN = NO_IPN*WEIGHT_W/WORD_W (words per neuron, integer >= 1); N_WORDS = NO_NPL*WPN; ADDR_W = max(1, clog2(N_WORDS)).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  single-cycle request to load all weights.
REQ-009 rom_r_en  output  1  ROM read enable.
REQ-010 rom_addr  output  ADDR_W  ROM word address.
REQ-011 rom_data  input  WORD_W  ROM read data, valid the cycle after rom_r_en.
REQ-012 node_wr_en  output  NO_NPL  one-hot FIFO write strobes.
REQ-013 node_data  output  WORD_W  data to all neuron FIFOs.
REQ-014 node_full  input  NO_NPL  per-FIFO full flags.
REQ-015 busy  output  1  high whenever state != IDLE.
REQ-016 done  output  1  one-cycle pulse after last word written.
REQ-017 words_written  output  ADDR_W+1  words written in current/last load.

Function
REQ-018 States: IDLE, FETCH, CAPTURE, WRITE, DONE; state, address and data registers only.
REQ-019 IDLE: start=1 -> FETCH, addr cleared to 0, words_written cleared to 0; start=0 -> stay.
REQ-020 FETCH (1 cycle): rom_r_en=1, rom_addr=addr -> CAPTURE.
REQ-021 CAPTURE (1 cycle): rom_data latched into word register -> WRITE.
REQ-022 WRITE: target node k = addr / WPN; node_data = latched word at all times in this state.
REQ-023 WRITE, node_full[k]=0: node_wr_en = one-hot bit k for exactly that cycle; words_written +1.
REQ-024 After a write: addr = N_WORDS-1 -> DONE; else addr +1 -> FETCH.
REQ-025 WRITE, node_full[k]=1: node_wr_en = 0, stay in WRITE with word and addr held; no ROM read issued; no timeout.
REQ-026 Fullness of FIFOs other than k is ignored.
REQ-027 DONE (1 cycle): done=1 -> IDLE.
REQ-028 start outside IDLE is ignored: not queued, no restart.
REQ-029 rom_r_en = 0 in all states except FETCH; node_wr_en = 0 in all states except WRITE.
REQ-030 rom_addr = addr in all states; it holds after DONE until the next start.
REQ-031 words_written holds its final value (N_WORDS) after DONE until the next start.
REQ-032 Unstalled timing, start sampled at edge T:
  - rom_r_en in cycle T+1.
  - Word i written in cycle T+3+3i.
  - done in cycle T+3*N_WORDS+1.
  - busy high T+1 through T+3*N_WORDS+1.
REQ-033 Each stall cycle in WRITE delays all later events by one cycle.

Reset
REQ-034 rst=1 at an edge forces state IDLE; addr, word register and words_written to 0.
REQ-035 During and after rst, until the next start: rom_r_en=0, node_wr_en=0, busy=0, done=0, rom_addr=0, node_data=0.
REQ-036 rst mid-load aborts immediately: no further writes, no done pulse; the partial load is not resumed.
REQ-037 rst has priority over start in the same cycle.

Verification
REQ-038 Defaults; ROM = 1234,5678,9ABC,DEF0 (hex); no full; start at T:
  - writes at T+3/6/9/12 with node_wr_en = 0001/0010/0100/1000 and node_data = 1234/5678/9ABC/DEF0.
  - done at T+13; words_written = 4.
REQ-039 As REQ-038 with node_full[2]=1 for 5 cycles from T+9:
  - node 2 write (9ABC) at T+14.
  - node 3 write (DEF0) at T+17.
  - done at T+18.
  - no writes during the stall.
REQ-040 start pulsed again at T+5 and T+10 during a load: ignored, trace identical to REQ-038.
REQ-041 rst at T+7 of a load:
  - from T+8: busy=0, node_wr_en=0, words_written=0; no done.
  - new start at T+20: full 4-word sequence repeats correctly.
REQ-042 Back-to-back: start at done cycle+1 -> second load with identical timing relative to its start.
REQ-043 NO_IPN=8 (WPN=2, N_WORDS=8):
  - words 0,1 go to node 0, words 2,3 to node 1, etc.
  - done at T+25.
